// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and default sizes for the hazard scoreboard unit
package hazard_pkg;
  localparam int DEF_NREG = 32;
  localparam int DEF_REGW = $clog2(DEF_NREG);
  localparam int DEF_MC_DEPTH = 2;
  localparam int DEF_CNTW = 32;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_e;
endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: pipeline-side signals seen by the hazard unit
interface hazard_scoreboard_unit_if import hazard_pkg::*; #(
  parameter int REGW = DEF_REGW,
  parameter int CNTW = DEF_CNTW
);
  logic [REGW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, McRd;
  logic RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE, McStartE, McDone, DmemReadyM;
  fwd_sel_e ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, McBusy, McErr;
  logic [CNTW-1:0] StallCycles;
  modport master (
    output Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, McRd,
    output RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE, McStartE, McDone, DmemReadyM,
    input ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input FlushD, FlushE, FlushM, FlushW, McBusy, McErr, StallCycles
  );
  modport slave (
    input Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, McRd,
    input RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE, McStartE, McDone, DmemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushM, FlushW, McBusy, McErr, StallCycles
  );
endinterface

// File: rtl/hazard_sb_core.sv
// hazard_sb_core: pending-destination scoreboard, outstanding MC count and sticky error
module hazard_sb_core import hazard_pkg::*; #(
  parameter int NREG = DEF_NREG,
  parameter int REGW = $clog2(NREG),
  parameter int MC_DEPTH = DEF_MC_DEPTH,
  parameter int CW = $clog2(MC_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_i,
  input  logic [REGW-1:0] rd_e_i,
  input  logic            mc_done_i,
  input  logic [REGW-1:0] mc_rd_i,
  input  logic [REGW-1:0] rs1_d_i,
  input  logic [REGW-1:0] rs2_d_i,
  input  logic [REGW-1:0] rd_d_i,
  output logic            sb_stall_o,
  output logic [CW-1:0]   count_o,
  output logic            mc_err_o
);
  logic [NREG-1:0] pending_q, pending_d, set_v, clr_v;
  logic [CW-1:0] count_q, count_d;
  logic mc_err_q, mc_err_d, done_bad, done_ok, accept;
  assign done_bad = mc_done_i && (count_q == '0 || (mc_rd_i != '0 && !pending_q[mc_rd_i]));
  assign done_ok = mc_done_i && !done_bad;
  // an issue into a full unit is only legal when a slot frees the same cycle
  assign accept = issue_i && (count_q != CW'(MC_DEPTH) || done_ok);
  assign set_v = (accept && rd_e_i != '0) ? NREG'(1) << rd_e_i : '0;
  assign clr_v = done_ok ? NREG'(1) << mc_rd_i : '0;
  assign pending_d = (pending_q & ~clr_v) | set_v;
  assign count_d = count_q + CW'(accept) - CW'(done_ok);
  assign mc_err_d = mc_err_q | done_bad;
  always_ff @(posedge clk) begin
    pending_q <= reset ? '0 : pending_d;
    count_q   <= reset ? '0 : count_d;
    mc_err_q  <= reset ? 1'b0 : mc_err_d;
  end
  assign sb_stall_o = pending_q[rs1_d_i] | pending_q[rs2_d_i] | pending_q[rd_d_i];
  assign count_o = count_q;
  assign mc_err_o = mc_err_q;
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: E-stage forwarding, prioritised stall/flush and stall-cycle counter
module hazard_scoreboard_unit import hazard_pkg::*; #(
  parameter int NREG = DEF_NREG,
  parameter int REGW = $clog2(NREG),
  parameter int MC_DEPTH = DEF_MC_DEPTH,
  parameter int CNTW = DEF_CNTW
) (
  input logic clk,
  input logic reset,
  hazard_scoreboard_unit_if.slave hz
);
  localparam int CW = $clog2(MC_DEPTH + 1);
  logic mem_stall, ld_stall, mc_use, sb_stall, mc_full, dep_stall, issue, quiet;
  logic [CW-1:0] count;
  logic [CNTW-1:0] stall_cycles_q, stall_cycles_d;
  assign hz.ForwardAE = (hz.RegWriteM && hz.RdM == hz.Rs1E && hz.Rs1E != '0) ? FWD_M :
                        (hz.RegWriteW && hz.RdW == hz.Rs1E && hz.Rs1E != '0) ? FWD_W : FWD_RF;
  assign hz.ForwardBE = (hz.RegWriteM && hz.RdM == hz.Rs2E && hz.Rs2E != '0) ? FWD_M :
                        (hz.RegWriteW && hz.RdW == hz.Rs2E && hz.Rs2E != '0) ? FWD_W : FWD_RF;
  assign mem_stall = !hz.DmemReadyM;
  assign ld_stall = hz.ResultSrcEb0 && hz.RdE != '0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
  assign mc_use = hz.McStartE && hz.RdE != '0 &&
                  (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D || hz.RdE == hz.RdD);
  assign mc_full = hz.McStartE && count == CW'(MC_DEPTH) && !hz.McDone;
  assign dep_stall = ld_stall | mc_use | sb_stall;
  assign quiet = !mem_stall && !mc_full;
  assign hz.StallM = mem_stall;
  assign hz.StallE = mem_stall | mc_full;
  assign hz.StallD = mem_stall | mc_full | dep_stall;
  assign hz.StallF = hz.StallD;
  assign hz.FlushW = mem_stall;
  assign hz.FlushM = !mem_stall && mc_full;
  assign hz.FlushE = quiet && (dep_stall || hz.PCSrcE);
  assign hz.FlushD = quiet && hz.PCSrcE;
  assign issue = hz.McStartE && !hz.StallE && !reset;
  hazard_sb_core #(.NREG(NREG), .REGW(REGW), .MC_DEPTH(MC_DEPTH), .CW(CW)) u_sb (
    .clk(clk), .reset(reset), .issue_i(issue), .rd_e_i(hz.RdE),
    .mc_done_i(hz.McDone), .mc_rd_i(hz.McRd),
    .rs1_d_i(hz.Rs1D), .rs2_d_i(hz.Rs2D), .rd_d_i(hz.RdD),
    .sb_stall_o(sb_stall), .count_o(count), .mc_err_o(hz.McErr)
  );
  assign hz.McBusy = count != '0;
  assign stall_cycles_d = (hz.StallF && !(&stall_cycles_q)) ? stall_cycles_q + 1'b1 : stall_cycles_q;
  always_ff @(posedge clk) stall_cycles_q <= reset ? '0 : stall_cycles_d;
  assign hz.StallCycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed vectors checked against a per-cycle behavioural model
module tb_hazard_scoreboard_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  bit armed = 1'b0;
  int checks = 0;
  int errors = 0;
  bit pend [32];
  int cnt = 0;
  bit err = 1'b0;
  longint sc = 0;
  hazard_scoreboard_unit_if hz ();
  hazard_scoreboard_unit dut (.clk(clk), .reset(reset), .hz(hz));
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [1:0] exp_fwd(input int rs);
    if (rs != 0 && hz.RegWriteM && int'(hz.RdM) == rs) return 2'b10;
    if (rs != 0 && hz.RegWriteW && int'(hz.RdW) == rs) return 2'b01;
    return 2'b00;
  endfunction
  initial begin
    logic [7:0] e, got;
    bit mem, ld, mu, sb, full, bad, ok, iss;
    int r1, r2, rdd, rde;
    wait (armed);
    forever begin
      @(negedge clk);
      r1 = int'(hz.Rs1D); r2 = int'(hz.Rs2D); rdd = int'(hz.RdD); rde = int'(hz.RdE);
      mem = !hz.DmemReadyM;
      ld = hz.ResultSrcEb0 && rde != 0 && (rde == r1 || rde == r2);
      mu = hz.McStartE && rde != 0 && (rde == r1 || rde == r2 || rde == rdd);
      sb = (r1 != 0 && pend[r1]) || (r2 != 0 && pend[r2]) || (rdd != 0 && pend[rdd]);
      full = hz.McStartE && cnt == 2 && !hz.McDone;
      // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
      if (mem) e = 8'b1111_0001;
      else if (full) e = 8'b1110_0010;
      else if (ld || mu || sb) e = {4'b1100, hz.PCSrcE, 3'b100};
      else if (hz.PCSrcE) e = 8'b0000_1100;
      else e = 8'b0;
      got = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW};
      check("stall_flush", {24'b0, got}, {24'b0, e});
      check("ForwardAE", {30'b0, hz.ForwardAE}, {30'b0, exp_fwd(int'(hz.Rs1E))});
      check("ForwardBE", {30'b0, hz.ForwardBE}, {30'b0, exp_fwd(int'(hz.Rs2E))});
      check("McBusy", {31'b0, hz.McBusy}, {31'b0, cnt != 0});
      check("McErr", {31'b0, hz.McErr}, {31'b0, err});
      check("StallCycles", hz.StallCycles, sc[31:0]);
      if (reset) begin
        foreach (pend[i]) pend[i] = 1'b0;
        cnt = 0; err = 1'b0; sc = 0;
      end else begin
        bad = hz.McDone && (cnt == 0 || (hz.McRd != 0 && !pend[hz.McRd]));
        ok = hz.McDone && !bad;
        iss = hz.McStartE && !e[5] && (cnt < 2 || ok);
        if (ok) pend[hz.McRd] = 1'b0;
        if (iss && rde != 0) pend[rde] = 1'b1;
        cnt = cnt + int'(iss) - int'(ok);
        if (bad) err = 1'b1;
        if (e[7] && sc < 64'hFFFF_FFFF) sc++;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {hz.Rs1D, hz.Rs2D, hz.RdD, hz.Rs1E, hz.Rs2E, hz.RdE, hz.RdM, hz.RdW, hz.McRd} = '0;
    {hz.RegWriteM, hz.RegWriteW, hz.ResultSrcEb0, hz.PCSrcE, hz.McStartE, hz.McDone} = '0;
    hz.DmemReadyM = 1'b1;
  endtask
  initial begin
    idle();
    tick();
    armed = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_StallCycles", hz.StallCycles, 32'd0);
    check("rst_McBusy", {31'b0, hz.McBusy}, 32'd0);
    check("rst_McErr", {31'b0, hz.McErr}, 32'd0);
    tick();
    hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1; #1;
    check("fwd_M_wins", {30'b0, hz.ForwardAE}, 32'd2);
    tick(); hz.RegWriteM = 0; #1;
    check("fwd_W", {30'b0, hz.ForwardAE}, 32'd1);
    tick(); hz.Rs1E = 0; #1;
    check("fwd_x0", {30'b0, hz.ForwardAE}, 32'd0);
    tick(); idle(); hz.ResultSrcEb0 = 1; hz.RdE = 7; hz.Rs2D = 7; #1;
    check("ld_stall", {29'b0, hz.StallF, hz.StallD, hz.FlushE}, 32'b111);
    tick(); idle(); #1;
    check("ld_release", {31'b0, hz.StallF}, 32'd0);
    check("ld_cycles", hz.StallCycles, 32'd1);
    tick(); hz.McStartE = 1; hz.RdE = 9;
    tick(); idle(); hz.Rs1D = 9; #1;
    check("sb_raw", {30'b0, hz.StallF, hz.McBusy}, 32'b11);
    tick();
    tick(); hz.McDone = 1; hz.McRd = 9; #1;
    check("sb_hold_on_done", {31'b0, hz.StallF}, 32'd1);
    tick(); hz.McDone = 0; #1;
    check("sb_release", {30'b0, hz.StallF, hz.McBusy}, 32'b00);
    check("sb_cycles", hz.StallCycles, 32'd4);
    tick(); idle(); hz.McStartE = 1; hz.RdE = 10;
    tick(); hz.RdE = 11;
    tick(); hz.RdE = 12; #1;
    check("mc_full", {27'b0, hz.StallF, hz.StallE, hz.FlushM, hz.FlushD, hz.FlushE}, 32'b11100);
    tick(); hz.McDone = 1; hz.McRd = 10; #1;
    check("mc_full_done", {30'b0, hz.StallE, hz.FlushM}, 32'b00);
    tick(); hz.McDone = 0; hz.RdE = 13; #1;
    check("mc_still_full", {31'b0, hz.StallE}, 32'd1);
    tick(); idle(); hz.McDone = 1; hz.McRd = 11;
    tick(); hz.McRd = 12;
    tick(); idle(); #1;
    check("mc_drained", {31'b0, hz.McBusy}, 32'd0);
    tick(); hz.DmemReadyM = 0; hz.PCSrcE = 1; hz.ResultSrcEb0 = 1; hz.RdE = 7; hz.Rs1D = 7; #1;
    check("mem_prio", {24'b0, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                       hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW}, 32'b1111_0001);
    tick(); hz.DmemReadyM = 1; #1;
    check("ld_branch", {27'b0, hz.StallF, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM}, 32'b10110);
    tick(); hz.ResultSrcEb0 = 0; #1;
    check("branch_only", {29'b0, hz.StallF, hz.FlushD, hz.FlushE}, 32'b011);
    tick(); idle(); hz.McStartE = 1; hz.RdE = 20; hz.RdD = 20; #1;
    check("mc_use_waw", {29'b0, hz.StallF, hz.StallE, hz.FlushE}, 32'b101);
    tick(); hz.McStartE = 0; hz.RdE = 0; #1;
    check("sb_waw", {31'b0, hz.StallF}, 32'd1);
    tick(); hz.McDone = 1; hz.McRd = 20;
    tick(); idle(); hz.McStartE = 1; hz.RdE = 3;
    tick(); hz.RdE = 4; reset = 1;
    tick(); reset = 0; idle(); hz.Rs1D = 3; #1;
    check("rst_clears", {30'b0, hz.StallF, hz.McBusy}, 32'b00);
    check("rst_cycles", hz.StallCycles, 32'd0);
    tick(); hz.McDone = 1; hz.McRd = 3; #1;
    check("err_before", {31'b0, hz.McErr}, 32'd0);
    tick(); idle(); #1;
    check("err_sticky", {31'b0, hz.McErr}, 32'd1);
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
